// File: rtl/seven_segment_pkg.sv
// Shared codes and scan-state type for the seven-segment scan driver.
// Codes are what the downstream BCD-to-segment decoder understands.
package seven_segment_pkg;

  localparam logic [3:0] BLANK_CODE = 4'hC;
  localparam logic [3:0] CODE_U     = 4'hA;
  localparam logic [3:0] CODE_DASH  = 4'hF;

  typedef enum logic {
    BLANK,
    SHOW
  } scan_state_e;

endpackage

// File: rtl/seven_segment_scanner_blanker.sv
// Leading-zero blanker: replaces zeros above the most significant
// nonzero digit with BLANK_CODE. Digit 0 always passes through.
module leading_zero_blanker
  import seven_segment_pkg::*;
#(
  parameter int NUM_DIGITS = 8
) (
  input  logic [4*NUM_DIGITS-1:0] digits_i,
  input  logic                    lz_i,
  output logic [4*NUM_DIGITS-1:0] digits_o
);

  logic lead;

  always_comb begin
    digits_o = digits_i;
    lead     = lz_i;
    for (int i = NUM_DIGITS - 1; i > 0; i--) begin
      if (lead && (digits_i[4*i +: 4] == 4'h0)) begin
        digits_o[4*i +: 4] = BLANK_CODE;
      end else begin
        lead = 1'b0;
      end
    end
  end

endmodule

// File: rtl/seven_segment_scanner.sv
// Multiplexed scan driver for an eight-digit seven-segment display,
// with frame-synchronous double buffering and leading-zero blanking.
module seven_segment_scanner
  import seven_segment_pkg::*;
#(
  parameter int NUM_DIGITS = 8,
  parameter int DIV        = 100000
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] digits_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic                    blank_lz,
  output logic [3:0]              bcd,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    dp,
  output logic                    frame_done
);

  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int CW = $clog2(DIV);
  localparam int DW = 4 * NUM_DIGITS;

  localparam logic [IW-1:0] IDX_LAST = IW'(NUM_DIGITS - 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);

  scan_state_e state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic [DW-1:0]         shadow_q, shadow_d;
  logic [NUM_DIGITS-1:0] shadow_dp_q, shadow_dp_d;
  logic                  shadow_lz_q, shadow_lz_d;
  logic [DW-1:0]         active_q, active_d;
  logic [NUM_DIGITS-1:0] active_dp_q, active_dp_d;

  logic [3:0]            bcd_q, bcd_d;
  logic [NUM_DIGITS-1:0] an_q, an_d;
  logic                  dp_q, dp_d;
  logic                  fd_q, fd_d;

  logic                  commit;
  logic [DW-1:0]         src_digits;
  logic [NUM_DIGITS-1:0] src_dp;
  logic                  src_lz;
  logic [DW-1:0]         blanked;

  // A load coinciding with the commit edge goes straight to the display.
  assign src_digits = load ? digits_in : shadow_q;
  assign src_dp     = load ? dp_in : shadow_dp_q;
  assign src_lz     = load ? blank_lz : shadow_lz_q;

  assign commit = (state_q == SHOW)
               && (cnt_q == CNT_LAST)
               && (idx_q == IDX_LAST);

  leading_zero_blanker #(
    .NUM_DIGITS (NUM_DIGITS)
  ) u_blanker (
    .digits_i (src_digits),
    .lz_i     (src_lz),
    .digits_o (blanked)
  );

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      BLANK: begin
        state_d = SHOW;
      end
      SHOW: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          state_d = BLANK;
          if (idx_q == IDX_LAST) begin
            idx_d = '0;
          end else begin
            idx_d = idx_q + IW'(1);
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
    endcase
  end

  always_comb begin
    shadow_d    = shadow_q;
    shadow_dp_d = shadow_dp_q;
    shadow_lz_d = shadow_lz_q;
    active_d    = active_q;
    active_dp_d = active_dp_q;
    if (load) begin
      shadow_d    = digits_in;
      shadow_dp_d = dp_in;
      shadow_lz_d = blank_lz;
    end
    if (commit) begin
      active_d    = blanked;
      active_dp_d = src_dp;
    end
  end

  // Outputs are decoded from next-state so they register in step.
  always_comb begin
    an_d  = '1;
    bcd_d = BLANK_CODE;
    dp_d  = 1'b1;
    fd_d  = commit;
    if (state_d == SHOW) begin
      an_d  = ~(NUM_DIGITS'(1) << idx_d);
      bcd_d = active_q[{idx_d, 2'b00} +: 4];
      dp_d  = ~active_dp_q[idx_d];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= BLANK;
      idx_q       <= '0;
      cnt_q       <= '0;
      shadow_q    <= {NUM_DIGITS{BLANK_CODE}};
      shadow_dp_q <= '0;
      shadow_lz_q <= 1'b0;
      active_q    <= {NUM_DIGITS{BLANK_CODE}};
      active_dp_q <= '0;
      bcd_q       <= BLANK_CODE;
      an_q        <= '1;
      dp_q        <= 1'b1;
      fd_q        <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      cnt_q       <= cnt_d;
      shadow_q    <= shadow_d;
      shadow_dp_q <= shadow_dp_d;
      shadow_lz_q <= shadow_lz_d;
      active_q    <= active_d;
      active_dp_q <= active_dp_d;
      bcd_q       <= bcd_d;
      an_q        <= an_d;
      dp_q        <= dp_d;
      fd_q        <= fd_d;
    end
  end

  assign bcd        = bcd_q;
  assign an         = an_q;
  assign dp         = dp_q;
  assign frame_done = fd_q;

endmodule

// File: tb/tb_seven_segment_scanner.sv
// Directed bench for seven_segment_scanner at DIV=4, eight digits.
// Expected frames are hand-computed code/dp patterns.
module tb_seven_segment_scanner;

  logic        clk;
  logic        rst_n;
  logic        load;
  logic [31:0] digits_in;
  logic [7:0]  dp_in;
  logic        blank_lz;
  logic [3:0]  bcd;
  logic [7:0]  an;
  logic        dp;
  logic        frame_done;

  int checks;
  int failures;

  seven_segment_scanner #(
    .NUM_DIGITS (8),
    .DIV        (4)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (load),
    .digits_in  (digits_in),
    .dp_in      (dp_in),
    .blank_lz   (blank_lz),
    .bcd        (bcd),
    .an         (an),
    .dp         (dp),
    .frame_done (frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic do_load(input logic [31:0] d,
                         input logic [7:0] p,
                         input logic lz);
    load      = 1'b1;
    digits_in = d;
    dp_in     = p;
    blank_lz  = lz;
    tick();
    load      = 1'b0;
  endtask

  task automatic wait_fd(input string tag);
    int n;
    n = 0;
    while (frame_done !== 1'b1 && n < 100) begin
      tick();
      n++;
    end
    chk({tag, "_fd_seen"}, {31'd0, frame_done}, 32'd1);
  endtask

  // Starts at a frame_done cycle, ends at the next one.
  task automatic check_frame(input string tag,
                             input logic [31:0] exp_bcd,
                             input logic [7:0] exp_dp);
    logic [12:0] ev;
    for (int i = 0; i < 8; i++) begin
      ev = {~(8'd1 << i), exp_bcd[4*i +: 4], ~exp_dp[i]};
      for (int c = 0; c < 4; c++) begin
        tick();
        chk($sformatf("%s_d%0d_c%0d", tag, i, c),
            {19'd0, an, bcd, dp}, {19'd0, ev});
      end
      tick();
      chk($sformatf("%s_gap%0d", tag, i),
          {19'd0, an, bcd, dp}, {19'd0, 8'hFF, 4'hC, 1'b1});
      chk($sformatf("%s_fd%0d", tag, i),
          {31'd0, frame_done}, {31'd0, (i == 7)});
    end
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    rst_n     = 1'b0;
    load      = 1'b0;
    digits_in = '0;
    dp_in     = '0;
    blank_lz  = 1'b0;

    repeat (3) tick();
    chk("rst_an", {24'd0, an}, 32'hFF);
    chk("rst_bcd", {28'd0, bcd}, 32'hC);
    chk("rst_dp", {31'd0, dp}, 32'd1);
    chk("rst_fd", {31'd0, frame_done}, 32'd0);

    rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      tick();
      chk($sformatf("first_show_c%0d", c),
          {19'd0, an, bcd, dp}, {19'd0, 8'hFE, 4'hC, 1'b1});
    end
    tick();
    chk("first_gap", {24'd0, an}, 32'hFF);
    tick();
    chk("second_digit", {24'd0, an}, 32'hFD);

    do_load(32'h0000_1234, 8'h04, 1'b1);
    wait_fd("lz1234");
    check_frame("lz1234", 32'hCCCC_1234, 8'h04);

    do_load(32'h0000_0000, 8'h00, 1'b1);
    wait_fd("zero_lz");
    check_frame("zero_lz", 32'hCCCC_CCC0, 8'h00);

    do_load(32'h0000_0000, 8'h00, 1'b0);
    wait_fd("zero_nolz");
    check_frame("zero_nolz", 32'h0000_0000, 8'h00);

    do_load(32'h000B_0E00, 8'h00, 1'b1);
    wait_fd("inner");
    check_frame("inner", 32'hCCCB_0E00, 8'h00);

    do_load(32'h1111_1111, 8'hFF, 1'b0);
    repeat (10) tick();
    do_load(32'hAFAF_AFAF, 8'h81, 1'b1);
    wait_fd("dbl");
    check_frame("dbl", 32'hAFAF_AFAF, 8'h81);

    repeat (39) tick();
    chk("bnd_pre_an", {24'd0, an}, 32'h7F);
    do_load(32'h9876_5430, 8'h10, 1'b0);
    chk("bnd_fd", {31'd0, frame_done}, 32'd1);
    check_frame("bnd", 32'h9876_5430, 8'h10);

    do_load(32'h5555_5555, 8'hFF, 1'b0);
    repeat (26) tick();
    chk("mid_idx5", {24'd0, an}, 32'hDF);
    rst_n = 1'b0;
    tick();
    chk("mid_rst_an", {24'd0, an}, 32'hFF);
    chk("mid_rst_bcd", {28'd0, bcd}, 32'hC);
    chk("mid_rst_dp", {31'd0, dp}, 32'd1);
    chk("mid_rst_fd", {31'd0, frame_done}, 32'd0);
    rst_n = 1'b1;
    tick();
    chk("mid_rel", {19'd0, an, bcd, dp}, {19'd0, 8'hFE, 4'hC, 1'b1});
    wait_fd("mid");
    check_frame("mid", 32'hCCCC_CCCC, 8'h00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
